// File: rtl/ldpc_llr_stream_tx.sv
// LDPC LLR ingress source: maps hard codeword bits to BPSK LLR beats and frames them.
// Optional LDPC_TX_PUNCTURE_EN zeroes beats 0 and 1 of every legal frame.
module ldpc_llr_stream_tx #(
  parameter int ZC      = 64,
  parameter int VWIDTH  = 8,
  parameter int LLR_MAG = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 C_VALID,
  output logic                 C_READY,
  input  logic                 C_LAST,
  input  logic [ZC-1:0]        C_DATA,
  input  logic                 W_READY,
  output logic                 W_VALID,
  output logic                 W_LAST,
  output logic [ZC*VWIDTH-1:0] W_DATA,
  output logic                 frame_done,
  output logic                 len_err,
  output logic                 mode_err
);

  localparam int DW = ZC * VWIDTH;
  localparam logic [VWIDTH-1:0] POS = VWIDTH'(LLR_MAG);
  localparam logic [VWIDTH-1:0] NEG = ~POS + 1'b1;

  typedef enum logic [1:0] {IDLE, SEND, PAD, REJECT} state_t;

  state_t          state, state_d;
  logic [4:0]      beat_cnt, cnt_d;
  logic [1:0]      frame_mode, fm_d, fm_cur;
  logic [4:0]      last_idx;
  logic [1:0]      fill, fill_d;
  logic [DW-1:0]   d0, d1, mapped, push_data;
  logic            l0, l1, push_last;
  logic            push, pop, acc, punc;
  logic            c_ready_q, c_ready_d;
  logic            len_err_q, len_set;
  logic            mode_err_q, merr_d;

`ifdef LDPC_TX_PUNCTURE_EN
  assign punc = (beat_cnt < 5'd2);
`else
  assign punc = 1'b0;
`endif

  assign acc      = C_VALID && c_ready_q;
  assign pop      = (fill != 2'd0) && W_READY;
  assign fm_cur   = (state == IDLE) ? mode : frame_mode;
  assign last_idx = (fm_cur == 2'd1) ? 5'd31 : 5'd23;

  always_comb begin
    mapped = '0;
    for (int k = 0; k < ZC; k++)
      mapped[k*VWIDTH +: VWIDTH] = punc ? '0 : (C_DATA[k] ? NEG : POS);
  end

  always_comb begin
    state_d   = state;
    cnt_d     = beat_cnt;
    fm_d      = frame_mode;
    push      = 1'b0;
    push_data = '0;
    push_last = 1'b0;
    len_set   = 1'b0;
    merr_d    = 1'b0;
    unique case (state)
      IDLE: if (acc) begin
        if (mode == 2'd1 || mode == 2'd2) begin
          fm_d      = mode;
          push      = 1'b1;
          push_data = mapped;
          cnt_d     = 5'd1;
          len_set   = C_LAST;
          state_d   = C_LAST ? PAD : SEND;
        end else begin
          merr_d  = 1'b1;
          state_d = C_LAST ? IDLE : REJECT;
        end
      end
      SEND: if (acc) begin
        push      = 1'b1;
        push_data = mapped;
        if (beat_cnt == last_idx) begin
          push_last = 1'b1;
          cnt_d     = 5'd0;
          len_set   = !C_LAST;
          state_d   = IDLE;
        end else begin
          cnt_d   = beat_cnt + 5'd1;
          len_set = C_LAST;
          if (C_LAST) state_d = PAD;
        end
      end
      // erasure fill after an early C_LAST
      PAD: if (fill != 2'd2) begin
        push = 1'b1;
        if (beat_cnt == last_idx) begin
          push_last = 1'b1;
          cnt_d     = 5'd0;
          state_d   = IDLE;
        end else begin
          cnt_d = beat_cnt + 5'd1;
        end
      end
      REJECT: if (acc && C_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fill_d    = fill + {1'b0, push} - {1'b0, pop};
  assign c_ready_d = (state_d == REJECT) ||
                     ((state_d != PAD) && (fill_d != 2'd2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= 5'd0;
      frame_mode <= 2'd0;
      c_ready_q  <= 1'b0;
      len_err_q  <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      state      <= state_d;
      beat_cnt   <= cnt_d;
      frame_mode <= fm_d;
      c_ready_q  <= c_ready_d;
      len_err_q  <= len_err_q | len_set;
      mode_err_q <= merr_d;
    end
  end

  // two-entry skid buffer, d0 is the head presented on W_
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= 2'd0;
      d0   <= '0;
      d1   <= '0;
      l0   <= 1'b0;
      l1   <= 1'b0;
    end else begin
      fill <= fill_d;
      if (push && !pop) begin
        if (fill == 2'd0) begin
          d0 <= push_data;
          l0 <= push_last;
        end else begin
          d1 <= push_data;
          l1 <= push_last;
        end
      end else if (pop) begin
        if (push && fill == 2'd1) begin
          d0 <= push_data;
          l0 <= push_last;
        end else begin
          d0 <= d1;
          l0 <= l1;
          if (push) begin
            d1 <= push_data;
            l1 <= push_last;
          end
        end
      end
    end
  end

  assign C_READY    = c_ready_q;
  assign W_VALID    = (fill != 2'd0);
  assign W_LAST     = W_VALID && l0;
  assign W_DATA     = d0;
  assign frame_done = pop && l0;
  assign len_err    = len_err_q;
  assign mode_err   = mode_err_q;

endmodule

// File: tb/tb_ldpc_llr_stream_tx.sv
// Directed bench for ldpc_llr_stream_tx: framing, mapping, stalls, errors, reset.
// Honours LDPC_TX_PUNCTURE_EN when the design is built with it.
module tb_ldpc_llr_stream_tx;

`ifdef LDPC_TX_PUNCTURE_EN
  localparam bit PUNC = 1'b1;
`else
  localparam bit PUNC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = 2'd1;
  logic         C_VALID = 1'b0;
  logic         C_READY;
  logic         C_LAST = 1'b0;
  logic [63:0]  C_DATA = '0;
  logic         W_READY = 1'b1;
  logic         W_VALID;
  logic         W_LAST;
  logic [511:0] W_DATA;
  logic         frame_done;
  logic         len_err;
  logic         mode_err;

  int tests = 0;
  int fails = 0;

  logic [511:0] rx_d[$];
  bit           rx_l[$];
  int           fd_cnt = 0;
  int           me_cnt = 0;
  int           crdy_low = 0;
  int           unstable = 0;
  bit           hold = 1'b0;
  logic [511:0] held_d;
  logic         held_l;

  ldpc_llr_stream_tx #(.ZC(64), .VWIDTH(8), .LLR_MAG(7)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .C_VALID(C_VALID), .C_READY(C_READY), .C_LAST(C_LAST), .C_DATA(C_DATA),
    .W_READY(W_READY), .W_VALID(W_VALID), .W_LAST(W_LAST), .W_DATA(W_DATA),
    .frame_done(frame_done), .len_err(len_err), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (W_VALID && W_READY) begin
        rx_d.push_back(W_DATA);
        rx_l.push_back(W_LAST);
      end
      if (hold && W_VALID && (W_DATA !== held_d || W_LAST !== held_l))
        unstable++;
      hold   = W_VALID && !W_READY;
      held_d = W_DATA;
      held_l = W_LAST;
      if (frame_done) fd_cnt++;
      if (mode_err) me_cnt++;
      if (!C_READY && !W_READY) crdy_low++;
    end
  end

  function automatic logic [63:0] bits_of(int i, logic [63:0] seed, bit vary);
    logic [7:0] b;
    b = 8'(i * 29 + 3);
    return vary ? (seed ^ {8{b}}) : seed;
  endfunction

  function automatic logic [511:0] exp_beat(logic [63:0] b);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[k*8 +: 8] = b[k] ? 8'hF9 : 8'h07;
    return r;
  endfunction

  task automatic clear_rx();
    rx_d.delete();
    rx_l.delete();
    fd_cnt = 0;
    me_cnt = 0;
    crdy_low = 0;
    unstable = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    C_VALID = 1'b0;
    C_LAST = 1'b0;
    W_READY = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_rx();
  endtask

  task automatic drive_frame(input logic [1:0] m, input int nb, input int last_at,
                             input logic [63:0] seed, input bit vary);
    int t;
    for (int i = 0; i < nb; i++) begin
      mode    = m;
      C_DATA  = bits_of(i, seed, vary);
      C_LAST  = (i == last_at);
      C_VALID = 1'b1;
      t = 0;
      @(negedge clk);
      while (!C_READY && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout beat %0d got no C_READY want C_READY=1", i);
      end
      @(posedge clk); #1;
    end
    C_VALID = 1'b0;
    C_LAST  = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_d.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (rx_d.size() !== n) begin
      fails++;
      $display("FAIL beat_count got %0d want %0d", rx_d.size(), n);
    end
  endtask

  // n beats from offset off; beats >= d are erasures
  task automatic check_frame(input string nm, input int off, input int n, input int d,
                             input logic [63:0] seed, input bit vary);
    logic [511:0] e;
    for (int i = 0; i < n; i++) begin
      if (off + i >= rx_d.size()) break;
      e = (i >= d || (PUNC && i < 2)) ? '0 : exp_beat(bits_of(i, seed, vary));
      tests++;
      if (rx_d[off+i] !== e) begin
        fails++;
        $display("FAIL %s_data beat %0d got %h want %h", nm, i, rx_d[off+i], e);
      end
      tests++;
      if (rx_l[off+i] !== (i == n - 1)) begin
        fails++;
        $display("FAIL %s_last beat %0d got %0b want %0b", nm, i, rx_l[off+i], i == n - 1);
      end
    end
  endtask

  task automatic check_val(input string nm, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_c_ready", int'(C_READY), 0);
    check_val("rst_w_valid", int'(W_VALID), 0);
    check_val("rst_w_last", int'(W_LAST), 0);
    check_val("rst_w_data_nz", int'(W_DATA != '0), 0);
    check_val("rst_flags", int'({frame_done, len_err, mode_err}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_c_ready", int'(C_READY), 1);
    clear_rx();
  endtask

  task automatic test_mode1_zero();
    drive_frame(2'd1, 32, 31, 64'h0, 1'b0);
    wait_rx(32);
    check_frame("m1_zero", 0, 32, 32, 64'h0, 1'b0);
    check_val("m1_frame_done", fd_cnt, 1);
    check_val("m1_len_err", int'(len_err), 0);
  endtask

  task automatic test_mode2_ones();
    clear_rx();
    drive_frame(2'd2, 24, 23, '1, 1'b0);
    wait_rx(24);
    check_frame("m2_ones", 0, 24, 24, '1, 1'b0);
    check_val("m2_frame_done", fd_cnt, 1);
    check_val("m2_len_err", int'(len_err), 0);
  endtask

  task automatic test_stall();
    int t;
    clear_rx();
    fork
      drive_frame(2'd1, 32, 31, 64'hA5A5_0F0F_3C3C_9696, 1'b1);
      begin
        t = 0;
        while (rx_d.size() < 10 && t < 500) begin
          @(posedge clk);
          t++;
        end
        #1 W_READY = 1'b0;
        repeat (5) @(posedge clk);
        #1 W_READY = 1'b1;
      end
    join
    wait_rx(32);
    check_frame("stall", 0, 32, 32, 64'hA5A5_0F0F_3C3C_9696, 1'b1);
    check_val("stall_c_ready_dropped", int'(crdy_low > 0), 1);
    check_val("stall_w_hold", unstable, 0);
    check_val("stall_frame_done", fd_cnt, 1);
  endtask

  task automatic test_short_frame();
    do_reset();
    drive_frame(2'd2, 10, 9, 64'h1234_5678_9ABC_DEF0, 1'b1);
    wait_rx(24);
    check_frame("short", 0, 24, 10, 64'h1234_5678_9ABC_DEF0, 1'b1);
    check_val("short_len_err", int'(len_err), 1);
    check_val("short_frame_done", fd_cnt, 1);
  endtask

  task automatic test_reject();
    do_reset();
    drive_frame(2'd3, 4, 3, 64'hFFFF_0000_FFFF_0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_val("reject_no_output", rx_d.size(), 0);
    check_val("reject_mode_err", me_cnt, 1);
    drive_frame(2'd1, 32, 31, 64'h0F0F_F0F0_0000_FFFF, 1'b1);
    wait_rx(32);
    check_frame("after_reject", 0, 32, 32, 64'h0F0F_F0F0_0000_FFFF, 1'b1);
    check_val("after_reject_mode_err", me_cnt, 1);
    check_val("after_reject_len_err", int'(len_err), 0);
  endtask

  task automatic test_reset_mid();
    int lasts = 0;
    do_reset();
    drive_frame(2'd1, 15, -1, 64'h5555_AAAA_5555_AAAA, 1'b1);
    rst = 1'b1;
    #1;
    check_val("midrst_outputs", int'({C_READY, W_VALID, W_LAST, frame_done,
                                      len_err, mode_err}), 0);
    check_val("midrst_w_data_nz", int'(W_DATA != '0), 0);
    foreach (rx_l[i]) if (rx_l[i]) lasts++;
    check_val("midrst_no_w_last", lasts, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_rx();
    drive_frame(2'd2, 24, 23, 64'hC3C3_3C3C_1111_EEEE, 1'b1);
    wait_rx(24);
    check_frame("midrst_next", 0, 24, 24, 64'hC3C3_3C3C_1111_EEEE, 1'b1);
  endtask

  task automatic test_no_last();
    do_reset();
    drive_frame(2'd2, 24, -1, 64'h0000_1111_2222_3333, 1'b1);
    wait_rx(24);
    check_frame("nolast", 0, 24, 24, 64'h0000_1111_2222_3333, 1'b1);
    check_val("nolast_len_err", int'(len_err), 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_frame(2'd2, 24, 23, 64'h8888_7777_6666_5555, 1'b1);
    drive_frame(2'd1, 32, 31, 64'h0123_4567_89AB_CDEF, 1'b1);
    wait_rx(56);
    check_frame("b2b_a", 0, 24, 24, 64'h8888_7777_6666_5555, 1'b1);
    check_frame("b2b_b", 24, 32, 32, 64'h0123_4567_89AB_CDEF, 1'b1);
    check_val("b2b_frame_done", fd_cnt, 2);
    check_val("b2b_len_err", int'(len_err), 0);
  endtask

  initial begin
    test_reset();
    test_mode1_zero();
    test_mode2_ones();
    test_stall();
    test_short_frame();
    test_reject();
    test_reset_mid();
    test_no_last();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
